// File: rtl/sm_debug_ctrl.sv
// Run/halt/step sequencer and register-dump engine for the schoolMIPS core.
// Gates the CPU clock enable and walks the debug read port for PC/register dumps.
//
// state | meaning
// ------+-----------------------------------------------------------------
// HALT  | CPU stopped; accepts RUN/STEP/DUMP commands
// RUN   | CPU free-running until a HALT command or a breakpoint match
// STEP  | CPU enabled for exactly stepCnt cycles, breakpoints ignored
// DUMP  | CPU stopped; streams PC then $1..$31 through the dump handshake
module sm_debug_ctrl #(
   parameter bit RESET_RUN = 1'b1,
   parameter int STEP_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   input  logic              bp_en,
   input  logic [31:0]       bp_pc,
   output logic              cpu_en,
   output logic [4:0]        reg_addr,
   input  logic [31:0]       reg_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [4:0]        dump_idx,
   output logic [31:0]       dump_data,
   output logic              halted,
   output logic              bp_hit
);

   typedef enum logic [1:0] {stHalt, stRun, stStep, stDump} state_t;

   localparam logic [1:0] opHalt = 2'b00;
   localparam logic [1:0] opRun  = 2'b01;
   localparam logic [1:0] opStep = 2'b10;
   localparam logic [1:0] opDump = 2'b11;

   state_t            state, stateNext;
   logic [STEP_W-1:0] stepCnt, stepNext;
   logic [4:0]        dumpCnt, dumpNext;
   logic              bpHit, bpHitNext;
   logic              arm, armNext;
   logic              cmdAcc;
   logic              bpMatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RESET_RUN ? stRun : stHalt;
         stepCnt <= '0;
         dumpCnt <= '0;
         bpHit   <= 1'b0;
         arm     <= 1'b0;
      end else begin
         state   <= stateNext;
         stepCnt <= stepNext;
         dumpCnt <= dumpNext;
         bpHit   <= bpHitNext;
         arm     <= armNext;
      end
   end

   // reg_addr is 0 outside DUMP, so reg_data carries the PC whenever bpMatch matters
   assign bpMatch = (state == stRun) && bp_en && arm && (reg_data == bp_pc);

   always_comb begin
      cpu_en = 1'b0;
      case (state)
         stRun:   cpu_en = !bpMatch;
         stStep:  cpu_en = 1'b1;
         default: cpu_en = 1'b0;
      endcase
   end

   assign cmd_ready  = (state == stHalt) || (state == stRun);
   assign cmdAcc     = cmd_valid && cmd_ready;
   assign reg_addr   = (state == stDump) ? dumpCnt : 5'd0;
   assign dump_valid = (state == stDump);
   assign dump_idx   = dumpCnt;
   assign dump_data  = reg_data;
   assign halted     = (state == stHalt);
   assign bp_hit     = bpHit;

   always_comb begin
      stateNext = state;
      stepNext  = stepCnt;
      dumpNext  = dumpCnt;
      bpHitNext = bpHit;
      armNext   = arm;
      case (state)
         stHalt: begin
            if (cmdAcc) begin
               case (cmd_op)
                  opRun: begin
                     stateNext = stRun;
                     bpHitNext = 1'b0;
                     armNext   = 1'b0;
                  end
                  opStep: begin
                     stateNext = stStep;
                     stepNext  = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
                  end
                  opDump: begin
                     stateNext = stDump;
                     dumpNext  = 5'd0;
                  end
                  default: stateNext = stHalt;
               endcase
            end
         end
         stRun: begin
            // Arming only after an executed cycle lets a resume step off the breakpoint PC
            if (cpu_en)
               armNext = 1'b1;
            if (bpMatch) begin
               stateNext = stHalt;
               bpHitNext = 1'b1;
            end else if (cmdAcc && (cmd_op == opHalt)) begin
               stateNext = stHalt;
            end
         end
         stStep: begin
            stepNext = stepCnt - STEP_W'(1);
            if (stepCnt <= STEP_W'(1))
               stateNext = stHalt;
         end
         stDump: begin
            if (dump_ready) begin
               dumpNext = dumpCnt + 5'd1;
               if (dumpCnt == 5'd31) begin
                  stateNext = stHalt;
                  dumpNext  = 5'd0;
               end
            end
         end
         default: stateNext = stHalt;
      endcase
   end

endmodule
